imem_loader: RTL

- Hardware counterpart of the bench-side instruction preload: fills the CPU's instruction memory from a byte stream, then releases the CPU.
- Sits between an external byte source (UART receiver or host bridge) and the write port of Instruction_Memory.
- Clears memory, writes incoming 32-bit words at consecutive word addresses, stops on the all-zero halt word, then asserts start_o to drive CPU start_i.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the loader and its environment.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;

    modport master (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_data_o
    );

    modport slave (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Clears instruction memory, loads little-endian words from a byte stream until the zero
// terminator (or memory full), then raises start_o to release the CPU.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    imem_loader_if.master     bus,
    output logic              busy_o,
    output logic              start_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              overflow_q, overflow_d;

    // The write port registers carry the action decided in the current state, so each
    // memory write becomes visible one cycle after the state that issued it.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_CLEAR: begin
                mem_we_d   = 1'b1;
                mem_addr_d = ptr_q;
                mem_data_d = 32'h0;
                ptr_d      = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.byte_valid_i) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_i;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we_d   = 1'b1;
                mem_addr_d = ptr_q;
                mem_data_d = asm_q;
                asm_d      = 32'h0;
                if (asm_q == 32'h0) begin
                    state_d = S_DONE;
                end else begin
                    word_count_d = word_count_q + 1'b1;
                    ptr_d        = ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        busy_d  = (state_d != S_DONE);
        start_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b1;
            start_q      <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.byte_ready_o = (state_q == S_LOAD);
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign busy_o           = busy_q;
    assign start_o          = start_q;
    assign word_count_o     = word_count_q;
    assign overflow_o       = overflow_q;

endmodule
